// File: rtl/round_controller.sv
// round_controller: round FSM with block-memory fill, frame/step sequencing,
// lives and blocks bookkeeping. Optional pause when ROUND_CTRL_PAUSE_EN is defined.
// Ports: clk_i, reset_i (sync, active-high), frame_tick_i, btn_release_i,
//   btn_pause_i (pause build only), start_update_o, step_complete_i,
//   hit_block_i, ball_lost_i, phys_* (port A request / phys_rdata_o),
//   mem_* (port A drive / mem_rdata_i), lives_o, blocks_left_o,
//   game_over_o, level_cleared_o.
module round_controller #(
  parameter int BLOCK_COUNT        = 72,
  parameter int STEPS_PER_FRAME    = 12,
  parameter int LIVES_INIT         = 3,
  parameter int CLEAR_PAUSE_FRAMES = 120
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic       btn_release_i,
`ifdef ROUND_CTRL_PAUSE_EN
  input  logic       btn_pause_i,
`endif
  output logic       start_update_o,
  input  logic       step_complete_i,
  input  logic       hit_block_i,
  input  logic       ball_lost_i,
  input  logic [6:0] phys_addr_i,
  input  logic       phys_we_i,
  input  logic       phys_wdata_i,
  output logic       phys_rdata_o,
  output logic [6:0] mem_addr_o,
  output logic       mem_we_o,
  output logic       mem_wdata_o,
  input  logic       mem_rdata_i,
  output logic [1:0] lives_o,
  output logic [6:0] blocks_left_o,
  output logic       game_over_o,
  output logic       level_cleared_o
);

  localparam int SW = $clog2(STEPS_PER_FRAME + 1);
  localparam int PW = $clog2(CLEAR_PAUSE_FRAMES + 1);
  localparam logic [6:0]    BC    = 7'(BLOCK_COUNT);
  localparam logic [1:0]    LI    = 2'(LIVES_INIT);
  localparam logic [SW-1:0] STEPS = SW'(STEPS_PER_FRAME);
  localparam logic [PW-1:0] PLAST = PW'(CLEAR_PAUSE_FRAMES - 1);

  typedef enum logic [2:0] {
    S_FILL, S_IDLE, S_RUN, S_CLEARED, S_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    fill_q, fill_d;
  logic          start_q, start_d;
  logic [1:0]    lives_q, lives_d;
  logic [6:0]    blocks_q, blocks_d;
  logic          over_q, over_d;
  logic          clr_q, clr_d;
  logic [SW-1:0] step_q, step_d, step_inc;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          hit_q, rel_q;
  logic          hit_rise, rel_rise;
  logic          paused;

`ifdef ROUND_CTRL_PAUSE_EN
  logic paused_q, pbtn_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      paused_q <= 1'b0;
      pbtn_q   <= 1'b0;
    end else begin
      pbtn_q <= btn_pause_i;
      if (btn_pause_i && !pbtn_q) paused_q <= ~paused_q;
    end
  end

  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  assign hit_rise = hit_block_i & ~hit_q;
  assign rel_rise = btn_release_i & ~rel_q;
  assign step_inc = step_q + SW'(1);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    start_d  = 1'b0;
    lives_d  = lives_q;
    blocks_d = blocks_q;
    over_d   = over_q;
    clr_d    = clr_q;
    step_d   = step_q;
    pcnt_d   = pcnt_q;
    if (hit_rise && blocks_q != 7'd0) blocks_d = blocks_q - 7'd1;
    if (ball_lost_i && lives_q != 2'd0) lives_d = lives_q - 2'd1;
    unique case (state_q)
      S_FILL: begin
        if (fill_q == BC) begin
          fill_d  = 7'd0;
          state_d = S_IDLE;
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      S_IDLE: begin
        if (frame_tick_i && !paused) begin
          start_d = 1'b1;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (step_complete_i) begin
          step_d = step_inc;
          // Decide on post-update counts so a hit/loss on the last step counts.
          if (step_inc == STEPS) begin
            if (blocks_d == 7'd0) begin
              state_d = S_CLEARED;
              clr_d   = 1'b1;
              pcnt_d  = '0;
            end else if (lives_d == 2'd0) begin
              state_d = S_OVER;
              over_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_CLEARED: begin
        if (frame_tick_i && !paused) begin
          if (pcnt_q == PLAST) begin
            state_d  = S_FILL;
            fill_d   = 7'd0;
            pcnt_d   = '0;
            blocks_d = BC;
            clr_d    = 1'b0;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end
      S_OVER: begin
        if (rel_rise) begin
          state_d  = S_FILL;
          fill_d   = 7'd0;
          lives_d  = LI;
          blocks_d = BC;
          over_d   = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_FILL;
      fill_q   <= 7'd0;
      start_q  <= 1'b0;
      lives_q  <= LI;
      blocks_q <= BC;
      over_q   <= 1'b0;
      clr_q    <= 1'b0;
      step_q   <= '0;
      pcnt_q   <= '0;
      hit_q    <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      start_q  <= start_d;
      lives_q  <= lives_d;
      blocks_q <= blocks_d;
      over_q   <= over_d;
      clr_q    <= clr_d;
      step_q   <= step_d;
      pcnt_q   <= pcnt_d;
      hit_q    <= hit_block_i;
      rel_q    <= btn_release_i;
    end
  end

  // Filler owns port A during FILL; physics sees it transparently otherwise.
  always_comb begin
    if (state_q == S_FILL) begin
      mem_addr_o   = fill_q;
      mem_we_o     = 1'b1;
      mem_wdata_o  = (fill_q != BC);
      phys_rdata_o = 1'b0;
    end else begin
      mem_addr_o   = phys_addr_i;
      mem_we_o     = phys_we_i;
      mem_wdata_o  = phys_wdata_i;
      phys_rdata_o = mem_rdata_i;
    end
  end

  assign start_update_o  = start_q;
  assign lives_o         = lives_q;
  assign blocks_left_o   = blocks_q;
  assign game_over_o     = over_q;
  assign level_cleared_o = clr_q;

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed + randomized bench for round_controller
// against a behavioural game model.
module tb_round_controller;

  localparam int BC  = 72;
  localparam int SPF = 12;
  localparam int LI  = 3;
  localparam int CPF = 120;

  localparam int MF = 0, MI = 1, MR = 2, MC = 3, MO = 4;

  logic clk = 1'b0;
  logic rst, tick, rel, pbtn, step, hit, lost;
  logic [6:0] paddr;
  logic pwe, pwd, mrd;
  logic su, prd, mwe, mwd, gover, lclr;
  logic [6:0] maddr, blocks;
  logic [1:0] lives;

  round_controller dut (
    .clk_i(clk), .reset_i(rst), .frame_tick_i(tick),
    .btn_release_i(rel),
`ifdef ROUND_CTRL_PAUSE_EN
    .btn_pause_i(pbtn),
`endif
    .start_update_o(su), .step_complete_i(step),
    .hit_block_i(hit), .ball_lost_i(lost),
    .phys_addr_i(paddr), .phys_we_i(pwe),
    .phys_wdata_i(pwd), .phys_rdata_o(prd),
    .mem_addr_o(maddr), .mem_we_o(mwe),
    .mem_wdata_o(mwd), .mem_rdata_i(mrd),
    .lives_o(lives), .blocks_left_o(blocks),
    .game_over_o(gover), .level_cleared_o(lclr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit m_valid = 0;
  int m_mode, m_lives, m_blocks, m_steps_left, m_pause_left;
  bit m_start, m_over, m_clr, m_hit_prev, m_rel_prev;
  bit m_paused, m_pbtn_prev;
  int fq[$];
  bit quiet_we = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void load_fill();
    fq.delete();
    for (int i = 0; i <= BC; i++) fq.push_back(i * 2 + ((i < BC) ? 1 : 0));
  endfunction

  function automatic void model_edge();
    bit hr, rr, pz;
    if (rst) begin
      m_valid = 1; m_mode = MF; load_fill();
      m_start = 0; m_lives = LI; m_blocks = BC;
      m_over = 0; m_clr = 0; m_hit_prev = 0; m_rel_prev = 0;
      m_paused = 0; m_pbtn_prev = 0;
      return;
    end
    hr = hit && !m_hit_prev;
    rr = rel && !m_rel_prev;
    m_hit_prev = hit;
    m_rel_prev = rel;
    pz = m_paused;
`ifdef ROUND_CTRL_PAUSE_EN
    if (pbtn && !m_pbtn_prev) m_paused = !m_paused;
    m_pbtn_prev = pbtn;
`endif
    m_start = 0;
    if (hr && m_blocks > 0) m_blocks--;
    if (lost && m_lives > 0) m_lives--;
    case (m_mode)
      MF: begin
        void'(fq.pop_front());
        if (fq.size() == 0) m_mode = MI;
      end
      MI: if (tick && !pz) begin
        m_mode = MR; m_start = 1; m_steps_left = SPF;
      end
      MR: if (step) begin
        m_steps_left--;
        if (m_steps_left == 0) begin
          if (m_blocks == 0) begin
            m_mode = MC; m_clr = 1; m_pause_left = CPF;
          end else if (m_lives == 0) begin
            m_mode = MO; m_over = 1;
          end else m_mode = MI;
        end
      end
      MC: if (tick && !pz) begin
        m_pause_left--;
        if (m_pause_left == 0) begin
          m_mode = MF; load_fill(); m_blocks = BC; m_clr = 0;
        end
      end
      MO: if (rr) begin
        m_mode = MF; load_fill();
        m_lives = LI; m_blocks = BC; m_over = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic compare();
    if (!m_valid) return;
    chk("start_update", su, m_start);
    chk("lives", lives, m_lives);
    chk("blocks_left", blocks, m_blocks);
    chk("game_over", gover, m_over);
    chk("level_cleared", lclr, m_clr);
    if (m_mode == MF) begin
      chk("fill_addr", maddr, fq[0] / 2);
      chk("fill_we", mwe, 1);
      chk("fill_wdata", mwd, fq[0] % 2);
      chk("fill_phys_rdata", prd, 0);
    end else begin
      chk("pass_addr", maddr, paddr);
      chk("pass_we", mwe, pwe);
      chk("pass_wdata", mwd, pwd);
      chk("pass_rdata", prd, mrd);
    end
  endtask

  task automatic rand_bus();
    paddr = 7'($urandom % 128);
    pwe = quiet_we ? 1'b0 : 1'($urandom % 2);
    pwd = 1'($urandom % 2);
    mrd = 1'($urandom % 2);
  endtask

  task automatic cycle_nb();
    #1 compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    rand_bus();
    cycle_nb();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) begin
      step = 1; cycle(); step = 0; cycle();
    end
  endtask

  task automatic frame(int nh, int nl);
    tick = 1; cycle(); tick = 0;
    for (int s = 0; s < SPF; s++) begin
      hit = (s < nh); lost = (s < nl); cycle();
      hit = 0; lost = 0; step = 1; cycle(); step = 0;
    end
    cycle();
  endtask

  task automatic pause_ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cycle(); tick = 0; cycle();
    end
  endtask

  task automatic count_fill(string nm);
    int n = 0, la = -1, ld = -1;
    quiet_we = 1;
    for (int i = 0; i < 90; i++) begin
      rand_bus();
      #1;
      if (mwe) begin n++; la = maddr; ld = mwd; end
      cycle_nb();
    end
    quiet_we = 0;
    chk({nm, "_we_count"}, n, BC + 1);
    chk({nm, "_last_addr"}, la, BC);
    chk({nm, "_last_data"}, ld, 0);
  endtask

  initial begin
    rst = 1; tick = 0; rel = 0; pbtn = 0;
    step = 0; hit = 0; lost = 0;
    rand_bus();
    @(negedge clk);
    idle(3);
    chk("rst_lives", lives, 3);
    chk("rst_blocks", blocks, 72);
    chk("rst_game_over", gover, 0);
    chk("rst_cleared", lclr, 0);
    chk("rst_start", su, 0);
    rst = 0;
    count_fill("fill0");

    // frame start latency, overrun drop, frame end
    tick = 1; cycle(); tick = 0;
    chk("su_latency", su, 1);
    tick = 1; cycle(); tick = 0;
    chk("overrun_no_su", su, 0);
    steps(11);
    tick = 1; cycle(); tick = 0;
    chk("mid_frame_no_su", su, 0);
    steps(1);
    tick = 1; cycle(); tick = 0;
    chk("next_frame_su", su, 1);
    steps(12);
    cycle();

    // held hit counts once, then clear the level
    tick = 1; cycle(); tick = 0;
    hit = 1; idle(3); hit = 0; cycle();
    chk("held_hit_blocks", blocks, 71);
    steps(12);
    cycle();
    for (int f = 0; f < 5; f++) frame(12, 0);
    frame(11, 0);
    chk("clear_flag", lclr, 1);
    chk("clear_blocks", blocks, 0);
    pause_ticks(CPF - 1);
    chk("clear_hold", lclr, 1);
    tick = 1; cycle(); tick = 0;
    chk("refill_cleared", lclr, 0);
    chk("refill_blocks", blocks, 72);
    chk("refill_lives", lives, 3);
    count_fill("fill1");

    // lives run out
    frame(0, 1); chk("lives_2", lives, 2);
    frame(0, 1); chk("lives_1", lives, 1);
    frame(0, 1); chk("lives_0", lives, 0);
    chk("over_flag", gover, 1);
    rel = 1; cycle(); rel = 0;
    chk("restart_over", gover, 0);
    chk("restart_lives", lives, 3);
    count_fill("fill2");

    // clear and final loss in the same frame
    frame(12, 1); frame(12, 1);
    frame(12, 0); frame(12, 0); frame(12, 0);
    frame(12, 1);
    chk("tie_cleared", lclr, 1);
    chk("tie_over", gover, 0);
    chk("tie_lives", lives, 0);
    pause_ticks(CPF);
    idle(80);
    chk("tie_lives_kept", lives, 0);
    frame(0, 0);
    chk("tie_then_over", gover, 1);
    rel = 1; cycle(); rel = 0;
    idle(80);

`ifdef ROUND_CTRL_PAUSE_EN
    begin
      int nsu = 0;
      pbtn = 1; cycle(); pbtn = 0; cycle();
      for (int i = 0; i < 5; i++) begin
        tick = 1; cycle(); tick = 0;
        if (su) nsu++;
        cycle();
        if (su) nsu++;
      end
      chk("paused_no_su", nsu, 0);
      pbtn = 1; cycle(); pbtn = 0; cycle();
      tick = 1; cycle(); tick = 0;
      chk("unpaused_su", su, 1);
      steps(12);
      cycle();
    end
`endif

    // randomized play against the model
    for (int c = 0; c < 30000; c++) begin
      rst = ($urandom % 5000 == 0);
      tick = 0; step = 0; hit = 0; lost = 0; rel = 0;
`ifdef ROUND_CTRL_PAUSE_EN
      pbtn = ($urandom % 400 == 0);
`endif
      case (m_mode)
        MI: tick = ($urandom % 4 == 0);
        MR: begin
          step = ($urandom % 3 == 0);
          hit  = ($urandom % 4 == 0);
          lost = ($urandom % 150 == 0);
          tick = ($urandom % 40 == 0);
        end
        MC: tick = ($urandom % 2 == 0);
        MO: rel = ($urandom % 6 == 0);
        default: ;
      endcase
      cycle();
    end
    rst = 0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
